cc_unit: RTL

CC_UNIT -- requirements
Module: cc_unit

---
 rtl/cc_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cc_unit.sv
// Condition-code unit: NZCV flag register, condition evaluator and a one-deep result buffer.
// Optional macro CC_SHADOW_EN adds an exception shadow copy of the flags (exc_save/exc_restore).
module cc_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       cc_we,
`ifdef CC_SHADOW_EN
  input  logic       exc_save,
  input  logic       exc_restore,
`endif
  input  logic       ev_valid,
  input  logic [3:0] cond,
  output logic       ev_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       cond_true,
  output logic [3:0] flags,
  output logic       ci
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_true_q, cond_true_d;
  logic       accept;

  // Flags are packed {N,Z,C,V}, MSB first.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cf;
      4'b0011: r = ~cf;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cf & ~z;
      4'b1001: r = ~cf | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      4'b1111: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign res_valid = (state_q == ST_FULL);
  assign ev_ready  = ~cc_we & (~res_valid | res_ready);
  assign accept    = ev_valid & ev_ready;
  assign cond_true = cond_true_q;
  assign flags     = flags_q;
  assign ci        = flags_q[1];

`ifdef CC_SHADOW_EN
  logic [3:0] shadow_q, shadow_d;

  // Restore beats cc_we; save and restore together swap flags and shadow.
  always_comb begin
    flags_d  = flags_q;
    shadow_d = shadow_q;
    if (exc_restore) begin
      flags_d = shadow_q;
    end else if (cc_we) begin
      flags_d = {alu_n, alu_z, alu_c, alu_v};
    end else begin
      flags_d = flags_q;
    end
    if (exc_save) begin
      shadow_d = flags_q;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Shadow register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= 4'b0000;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  // Flag register next state
  always_comb begin
    flags_d = flags_q;
    if (cc_we) begin
      flags_d = {alu_n, alu_z, alu_c, alu_v};
    end else begin
      flags_d = flags_q;
    end
  end
`endif

  // Result buffer next state; a held result is only replaced by a new accept.
  always_comb begin
    state_d     = state_q;
    cond_true_d = cond_true_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_FULL;
          cond_true_d = eval_cond(cond, flags_q);
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept) begin
          state_d     = ST_FULL;
          cond_true_d = eval_cond(cond, flags_q);
        end else if (res_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d     = ST_EMPTY;
        cond_true_d = 1'b0;
      end
    endcase
  end

  // State, flags and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      flags_q     <= 4'b0000;
      cond_true_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      cond_true_q <= cond_true_d;
    end
  end

endmodule
